// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// GATE_CYC-cycle window and publishes the saturating count with a valid strobe.
module freq_meter #(
  parameter int CLK_IN  = 100_000_000,
  parameter int GATE_HZ = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);
  localparam int GATE_CYC = CLK_IN / GATE_HZ;
  localparam int GATE_W   = $clog2(GATE_CYC);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE, GATE} state_t;

  state_t            state, state_nxt;
  logic              s1, s2, s3;
  logic              rise;
  logic [GATE_W-1:0] gate_cnt, gate_cnt_nxt;
  logic [CNT_W-1:0]  edge_cnt, edge_cnt_nxt;
  logic              sat, sat_nxt;
  logic [CNT_W-1:0]  freq_nxt;
  logic              ovf_nxt, valid_nxt;
  logic [CNT_W:0]    sum;

  // Returns {saturated, result}; holds at all-ones instead of wrapping.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a, input logic inc);
    if (inc && (a == CNT_MAX)) return {1'b1, CNT_MAX};
    return {1'b0, a + CNT_W'(inc)};
  endfunction

  assign rise = s2 & ~s3;
  assign sum  = sat_add(edge_cnt, rise);

  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = gate_cnt;
    edge_cnt_nxt = edge_cnt;
    sat_nxt      = sat;
    freq_nxt     = freq;
    ovf_nxt      = ovf;
    valid_nxt    = 1'b0;
    case (state)
      IDLE: begin
        gate_cnt_nxt = '0;
        edge_cnt_nxt = '0;
        sat_nxt      = 1'b0;
        if (en) state_nxt = GATE;
      end
      GATE: begin
        if (gate_cnt == GATE_LAST) begin
          // Window end publishes even if en drops in this same cycle.
          freq_nxt     = sum[CNT_W-1:0];
          ovf_nxt      = sat | sum[CNT_W];
          valid_nxt    = 1'b1;
          gate_cnt_nxt = '0;
          edge_cnt_nxt = '0;
          sat_nxt      = 1'b0;
          if (!en) state_nxt = IDLE;
        end else if (!en) begin
          state_nxt    = IDLE;
          gate_cnt_nxt = '0;
          edge_cnt_nxt = '0;
          sat_nxt      = 1'b0;
        end else begin
          gate_cnt_nxt = gate_cnt + GATE_W'(1);
          edge_cnt_nxt = sum[CNT_W-1:0];
          sat_nxt      = sat | sum[CNT_W];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      freq     <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      s1       <= sig_in;
      s2       <= s1;
      s3       <= s2;
      gate_cnt <= gate_cnt_nxt;
      edge_cnt <= edge_cnt_nxt;
      sat      <= sat_nxt;
      freq     <= freq_nxt;
      ovf      <= ovf_nxt;
      valid    <= valid_nxt;
      busy     <= (state_nxt == GATE);
    end
  end
endmodule
